// File: rtl/breakout_pkg.sv
// Shared constants and FSM state encoding for the brick RAM writer.
package breakout_pkg;

  localparam int BRICKS_PER_WALL = 128;
  localparam int BRICK_IDX_W     = 7;
  localparam int RAM_ADDR_W      = 8;
  localparam int CNT_W           = 8;

  localparam logic [BRICK_IDX_W-1:0] LAST_IDX   = BRICK_IDX_W'(BRICKS_PER_WALL - 1);
  localparam logic [BRICK_IDX_W-1:0] IDX_ONE    = BRICK_IDX_W'(1);
  localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(BRICKS_PER_WALL);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    HIT_RD = 2'd2,
    HIT_WR = 2'd3
  } wr_state_e;

endpackage

// File: rtl/brick_counter.sv
// Per-wall remaining-brick counter: load to full, saturating decrement,
// one-cycle pulse on the 1->0 transition.
module brick_counter
  import breakout_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero_pulse
);

  logic [CNT_W-1:0] r_count;

  // A load in the same cycle as a decrement wins: the wall is freshly refilled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= FULL_COUNT;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  assign o_count      = r_count;
  assign o_zero_pulse = i_dec && !i_load && (r_count == CNT_ONE);

endmodule

// File: rtl/brick_ram_writer.sv
// Sole write master of the 256x1 brick RAM: refills a wall on request and
// clears single bricks on hit requests, keeping per-wall brick counts.
module brick_ram_writer
  import breakout_pkg::*;
(
  input  logic                   CLK_DRV,
  input  logic                   RESET_N,
  input  logic                   FILL_REQ,
  input  logic                   PLAYER,
  input  logic                   HIT_REQ,
  input  logic [BRICK_IDX_W-1:0] HIT_ADDR,
  output logic                   HIT_ACK,
  input  logic                   WR_WINDOW,
  output logic [RAM_ADDR_W-1:0]  RAM_ADDR,
  output logic                   RAM_DIN,
  output logic                   RAM_WE,
  input  logic                   RAM_DOUT,
  output logic                   BUSY,
  output logic [CNT_W-1:0]       BRICKS_LEFT,
  output logic                   WALL_CLEAR
);

  wr_state_e              r_state;
  wr_state_e              w_state_nxt;
  logic [BRICK_IDX_W-1:0] r_idx;
  logic [BRICK_IDX_W-1:0] w_idx_nxt;
  logic                   r_rd_phase;
  logic                   w_rd_phase_nxt;
  logic                   r_fill_pend;
  logic                   r_fill_player;
  logic                   r_ack_d;
  logic                   r_hit_player;
  logic [BRICK_IDX_W-1:0] r_hit_idx;

  logic                   w_fill_done;
  logic                   w_hit_start;
  logic                   w_dec;
  logic [CNT_W-1:0]       w_cnt0;
  logic [CNT_W-1:0]       w_cnt1;
  logic                   w_zero0;
  logic                   w_zero1;

  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_rd_phase <= 1'b0;
      r_ack_d    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_rd_phase <= w_rd_phase_nxt;
      r_ack_d    <= HIT_ACK;
    end
  end

  // A new request re-latches the wall even mid-sweep, which restarts the fill.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fill_pend   <= 1'b0;
      r_fill_player <= 1'b0;
    end else if (FILL_REQ) begin
      r_fill_pend   <= 1'b1;
      r_fill_player <= PLAYER;
    end else if (w_fill_done) begin
      r_fill_pend   <= 1'b0;
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (w_hit_start) begin
      r_hit_player <= PLAYER;
      r_hit_idx    <= HIT_ADDR;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_rd_phase_nxt = 1'b0;
    w_fill_done    = 1'b0;
    w_hit_start    = 1'b0;
    w_dec          = 1'b0;
    RAM_ADDR       = '0;
    RAM_DIN        = 1'b0;
    RAM_WE         = 1'b0;
    HIT_ACK        = 1'b0;

    case (r_state)
      IDLE: begin
        // The cycle right after an ACK is skipped so a held request is not re-served.
        if (!r_ack_d) begin
          if (r_fill_pend) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
          end else if (HIT_REQ) begin
            w_state_nxt = HIT_RD;
            w_hit_start = 1'b1;
          end
        end
      end

      FILL: begin
        RAM_ADDR = {r_fill_player, r_idx};
        RAM_DIN  = 1'b1;
        RAM_WE   = WR_WINDOW;
        if (FILL_REQ) begin
          w_idx_nxt = '0;
        end else if (WR_WINDOW) begin
          if (r_idx == LAST_IDX) begin
            w_fill_done = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end
      end

      HIT_RD: begin
        // Phase 0 presents the address; RAM_DOUT is valid in phase 1.
        RAM_ADDR = {r_hit_player, r_hit_idx};
        if (!r_rd_phase) begin
          w_rd_phase_nxt = 1'b1;
        end else if (RAM_DOUT) begin
          w_state_nxt = HIT_WR;
        end else begin
          HIT_ACK     = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      HIT_WR: begin
        RAM_ADDR = {r_hit_player, r_hit_idx};
        if (WR_WINDOW) begin
          RAM_WE      = 1'b1;
          w_dec       = 1'b1;
          HIT_ACK     = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  brick_counter u_cnt_wall0 (
    .i_clk        (CLK_DRV),
    .i_rst_n      (RESET_N),
    .i_load       (w_fill_done && !r_fill_player),
    .i_dec        (w_dec && !r_hit_player),
    .o_count      (w_cnt0),
    .o_zero_pulse (w_zero0)
  );

  brick_counter u_cnt_wall1 (
    .i_clk        (CLK_DRV),
    .i_rst_n      (RESET_N),
    .i_load       (w_fill_done && r_fill_player),
    .i_dec        (w_dec && r_hit_player),
    .o_count      (w_cnt1),
    .o_zero_pulse (w_zero1)
  );

  assign BUSY        = (r_state != IDLE);
  assign BRICKS_LEFT = PLAYER ? w_cnt1 : w_cnt0;
  assign WALL_CLEAR  = w_zero0 | w_zero1;

endmodule

// File: tb/tb_brick_ram_writer.sv
// Scoreboard bench for brick_ram_writer: expected RAM writes are queued as
// stimulus is driven and retired by a write monitor on the falling edge.
module tb_brick_ram_writer;

  logic       CLK_DRV = 1'b0;
  logic       RESET_N;
  logic       FILL_REQ;
  logic       PLAYER;
  logic       HIT_REQ;
  logic [6:0] HIT_ADDR;
  logic       HIT_ACK;
  logic       WR_WINDOW;
  logic [7:0] RAM_ADDR;
  logic       RAM_DIN;
  logic       RAM_WE;
  logic       RAM_DOUT;
  logic       BUSY;
  logic [7:0] BRICKS_LEFT;
  logic       WALL_CLEAR;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb_q[$];

  brick_ram_writer dut (
    .CLK_DRV     (CLK_DRV),
    .RESET_N     (RESET_N),
    .FILL_REQ    (FILL_REQ),
    .PLAYER      (PLAYER),
    .HIT_REQ     (HIT_REQ),
    .HIT_ADDR    (HIT_ADDR),
    .HIT_ACK     (HIT_ACK),
    .WR_WINDOW   (WR_WINDOW),
    .RAM_ADDR    (RAM_ADDR),
    .RAM_DIN     (RAM_DIN),
    .RAM_WE      (RAM_WE),
    .RAM_DOUT    (RAM_DOUT),
    .BUSY        (BUSY),
    .BRICKS_LEFT (BRICKS_LEFT),
    .WALL_CLEAR  (WALL_CLEAR)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  // Every write must fall in an open window and match the next queued entry.
  always @(negedge CLK_DRV) begin
    if (RESET_N === 1'b1 && RAM_WE === 1'b1) begin
      logic [8:0] exp_w;
      checks++;
      if (WR_WINDOW !== 1'b1) begin
        failures++;
        $display("FAIL we_window: RAM_WE=1 with WR_WINDOW=%b, want WR_WINDOW=1", WR_WINDOW);
      end
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%0h din=%b, want no write", RAM_ADDR, RAM_DIN);
      end else begin
        exp_w = sb_q.pop_front();
        if ({RAM_ADDR, RAM_DIN} !== exp_w) begin
          failures++;
          $display("FAIL write_data: addr=%0h din=%b, want addr=%0h din=%b",
                   RAM_ADDR, RAM_DIN, exp_w[8:1], exp_w[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK_DRV);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b1; FILL_REQ = 1'b0; PLAYER = 1'b0; HIT_REQ = 1'b0;
    HIT_ADDR = '0; WR_WINDOW = 1'b1; RAM_DOUT = 1'b0;
    #2 RESET_N = 1'b0;
    #2;
    checks++;
    if ({BUSY, RAM_WE, RAM_DIN, HIT_ACK, WALL_CLEAR} !== 5'b0 || RAM_ADDR !== 8'h00
        || BRICKS_LEFT !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b we=%b din=%b ack=%b clr=%b addr=%0h left=%0d, want all 0",
               BUSY, RAM_WE, RAM_DIN, HIT_ACK, WALL_CLEAR, RAM_ADDR, BRICKS_LEFT);
    end
    repeat (2) @(posedge CLK_DRV);
    #1 RESET_N = 1'b1;
    step();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b, want 0", BUSY);
    end
  endtask

  task automatic test_fill(input logic pl, input logic toggle, input int exp_cycles);
    int cyc;
    for (int i = 0; i < 128; i++) sb_q.push_back({pl, 7'(i), 1'b1});
    PLAYER = pl; WR_WINDOW = 1'b1; FILL_REQ = 1'b1;
    step();
    FILL_REQ = 1'b0;
    step();
    cyc = 0;
    while (BUSY === 1'b1 && cyc < 600) begin
      WR_WINDOW = toggle ? cyc[0] : 1'b1;
      step();
      cyc++;
    end
    WR_WINDOW = 1'b1;
    checks++;
    if (cyc != exp_cycles) begin
      failures++;
      $display("FAIL fill_cycles: took %0d cycles, want %0d", cyc, exp_cycles);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL fill_writes: %0d writes missing, want 0", sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (BRICKS_LEFT !== 8'd128) begin
      failures++;
      $display("FAIL fill_count: bricks_left=%0d, want 128", BRICKS_LEFT);
    end
  endtask

  task automatic test_hit(input logic pl, input logic [6:0] a, input logic dout,
                          input logic [7:0] exp_cnt, input int exp_clear);
    int acks, clears, n;
    PLAYER = pl; HIT_ADDR = a; RAM_DOUT = dout; WR_WINDOW = 1'b1;
    if (dout) sb_q.push_back({pl, a, 1'b0});
    HIT_REQ = 1'b1;
    acks = 0; clears = 0; n = 0;
    while (acks == 0 && n < 20) begin
      step();
      n++;
      if (HIT_ACK === 1'b1) acks++;
      if (WALL_CLEAR === 1'b1) clears++;
    end
    step();
    HIT_REQ = 1'b0;
    repeat (3) begin
      if (HIT_ACK === 1'b1) acks++;
      if (WALL_CLEAR === 1'b1) clears++;
      step();
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL hit_ack: %0d acks for addr %0h, want 1", acks, {pl, a});
    end
    checks++;
    if (clears != exp_clear) begin
      failures++;
      $display("FAIL wall_clear: %0d pulses, want %0d", clears, exp_clear);
    end
    checks++;
    if (BRICKS_LEFT !== exp_cnt) begin
      failures++;
      $display("FAIL hit_count: bricks_left=%0d, want %0d", BRICKS_LEFT, exp_cnt);
    end
    checks++;
    if (sb_q.size() != 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL hit_done: pending=%0d busy=%b, want 0 and 0", sb_q.size(), BUSY);
      sb_q.delete();
    end
  endtask

  task automatic test_wall_clear();
    for (int i = 0; i < 127; i++) test_hit(1'b0, 7'(i), 1'b1, 8'(127 - i), 0);
    test_hit(1'b0, 7'd127, 1'b1, 8'd0, 1);
    test_hit(1'b0, 7'd0, 1'b1, 8'd0, 0);
  endtask

  task automatic test_fill_during_hit_reset();
    int n;
    PLAYER = 1'b1; HIT_ADDR = 7'h10; RAM_DOUT = 1'b1; WR_WINDOW = 1'b0;
    sb_q.push_back({1'b1, 7'h10, 1'b0});
    HIT_REQ = 1'b1;
    repeat (3) step();
    checks++;
    if (BUSY !== 1'b1 || RAM_WE !== 1'b0) begin
      failures++;
      $display("FAIL hit_stall: busy=%b we=%b, want 1 and 0", BUSY, RAM_WE);
    end
    PLAYER = 1'b0; FILL_REQ = 1'b1;
    step();
    FILL_REQ = 1'b0;
    for (int i = 0; i < 40; i++) sb_q.push_back({1'b0, 7'(i), 1'b1});
    WR_WINDOW = 1'b1;
    #1;
    checks++;
    if (HIT_ACK !== 1'b1) begin
      failures++;
      $display("FAIL hit_before_fill: ack=%b, want 1", HIT_ACK);
    end
    step();
    HIT_REQ = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL fill_to_40: pending=%0d busy=%b, want 0 and 1", sb_q.size(), BUSY);
      sb_q.delete();
    end
    PLAYER = 1'b1;
    #1;
    checks++;
    if (BRICKS_LEFT !== 8'd126) begin
      failures++;
      $display("FAIL hit_dec_wall1: bricks_left=%0d, want 126", BRICKS_LEFT);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || RAM_WE !== 1'b0 || RAM_ADDR !== 8'h00 || HIT_ACK !== 1'b0
        || BRICKS_LEFT !== 8'd0) begin
      failures++;
      $display("FAIL midfill_reset: busy=%b we=%b addr=%0h ack=%b left1=%0d, want all 0",
               BUSY, RAM_WE, RAM_ADDR, HIT_ACK, BRICKS_LEFT);
    end
    PLAYER = 1'b0;
    #1;
    checks++;
    if (BRICKS_LEFT !== 8'd0) begin
      failures++;
      $display("FAIL reset_wall0: bricks_left=%0d, want 0", BRICKS_LEFT);
    end
    @(posedge CLK_DRV);
    #1 RESET_N = 1'b1;
    repeat (3) step();
    checks++;
    if (BUSY !== 1'b0 || RAM_WE !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b we=%b pending=%0d, want 0 0 0",
               BUSY, RAM_WE, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill(1'b0, 1'b0, 128);
    test_fill(1'b1, 1'b1, 256);
    test_hit(1'b1, 7'h05, 1'b1, 8'd127, 0);
    test_hit(1'b1, 7'h05, 1'b0, 8'd127, 0);
    test_wall_clear();
    test_fill_during_hit_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/brick_ram_writer.md
BRICK_RAM_WRITER -- requirements
Module: brick_ram_writer

Interface
REQ-001 SHALL have port CLK_DRV  in  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-003 SHALL have port FILL_REQ  in  1  one-cycle pulse; refill the wall of PLAYER with bricks.
REQ-004 SHALL have port PLAYER  in  1  wall select; it is address bit 7 and selects the counter.
REQ-005 SHALL have port HIT_REQ  in  1  level request to clear one brick; held until HIT_ACK.
REQ-006 SHALL have port HIT_ADDR  in  7  brick index within the wall; stable while HIT_REQ=1.
REQ-007 SHALL have port HIT_ACK  out  1  one-cycle pulse completing a hit request.
REQ-008 SHALL have port WR_WINDOW  in  1  1 = RAM write port free this cycle (display not reading).
REQ-009 SHALL have port RAM_ADDR  out  8  {PLAYER, index} to the 256x1 brick RAM.
REQ-010 SHALL have port RAM_DIN  out  1  write data; 1 = brick present.
REQ-011 SHALL have port RAM_WE  out  1  write strobe; asserted only when WR_WINDOW=1.
REQ-012 SHALL have port RAM_DOUT  in  1  read data, valid one cycle after RAM_ADDR is driven.
REQ-013 SHALL have port BUSY  out  1  1 whenever the FSM is not IDLE.
REQ-014 SHALL have port BRICKS_LEFT  out  8  remaining-brick count of the wall selected by PLAYER.
REQ-015 SHALL have port WALL_CLEAR  out  1  one-cycle pulse when a wall count goes 1->0.

Function
REQ-016 SHALL implement the FSM states IDLE, FILL, HIT_RD and HIT_WR.
REQ-017 SHALL latch FILL_REQ into a pending flag in any state, together with the sampled PLAYER value.
REQ-018 In IDLE, SHALL go to FILL if fill is pending, else to HIT_RD if HIT_REQ=1; fill has priority.
REQ-019 FILL SHALL sweep the index 0..127 with RAM_DIN=1, writing one address per cycle with WR_WINDOW=1; the index SHALL hold while WR_WINDOW=0.
REQ-020 After the write at index 127, FILL SHALL set that wall's count to 128, clear the pending flag and return to IDLE.
REQ-021 A FILL_REQ arriving during FILL SHALL restart the sweep at index 0 with the newly sampled wall.
REQ-022 HIT_RD SHALL drive RAM_ADDR={PLAYER,HIT_ADDR} with RAM_WE=0 for one cycle, then sample RAM_DOUT.
REQ-023 If the sampled RAM_DOUT=1, SHALL enter HIT_WR, else SHALL pulse HIT_ACK and return to IDLE with no write and no count change.
REQ-024 HIT_WR SHALL wait for WR_WINDOW=1, write RAM_DIN=0 in that cycle, decrement the count, pulse HIT_ACK in the same cycle and return to IDLE.
REQ-025 A hit in progress SHALL complete before a pending fill starts; HIT_REQ asserted during FILL SHALL wait.
REQ-026 The count SHALL saturate at 0 and never exceed 128; WALL_CLEAR SHALL fire in the decrement cycle from 1 to 0.
REQ-027 After HIT_ACK, the FSM SHALL stay in IDLE for at least one cycle, so the requester can drop HIT_REQ without a double service.
REQ-028 RAM_WE SHALL never be 1 while WR_WINDOW=0; RAM_ADDR/RAM_DIN SHALL be 0 in IDLE.
REQ-029 The fill-completion load SHALL win over any decrement when both target the same wall in the same cycle.

Reset
REQ-030 RESET_N=0 SHALL immediately force IDLE, clear the pending fill and reset both counts to 0 and every output to 0, including mid-FILL or mid-HIT.
REQ-031 After reset release, operation SHALL begin on the first rising CLK_DRV edge.

Structure
REQ-032 breakout_pkg SHALL hold the FSM state enum, BRICKS_PER_WALL=128, BRICK_IDX_W=7 and RAM_ADDR_W=8.
REQ-033 The two per-wall counters SHALL be one sub-module, brick_counter (load 128, decrement, saturate, zero pulse), instantiated twice.
REQ-034 The RAM itself SHALL be outside this block; the only write source is the RAM_* port.

Verification
REQ-035 Reset, PLAYER=0, FILL_REQ pulse with WR_WINDOW=1 -> 128 writes to 0x00..0x7F with DIN=1 over 128 cycles, then BRICKS_LEFT=128.
REQ-036 Fill with WR_WINDOW toggling 1/0 -> no RAM_WE while the window=0, and completion after 256 cycles.
REQ-037 HIT_REQ with HIT_ADDR=0x05, PLAYER=1, RAM_DOUT=1 -> write addr 0x85 with DIN=0, one HIT_ACK, and count 128->127.
REQ-038 Repeat the same hit with RAM_DOUT=0 -> HIT_ACK with no RAM_WE and the count unchanged.
REQ-039 Count=1, valid hit -> count 0 and one WALL_CLEAR pulse; a further hit leaves the count at 0.
REQ-040 FILL_REQ during HIT_WR, then RESET_N low at fill index 40 -> the hit completes first, then the fill starts; after reset the state is IDLE, both counts are 0 and RAM_WE=0.
